// File: rtl/rsa_host_pkg.sv
// Shared types and constants for the RSA host-side controller.
package rsa_host_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } host_state_t;

    localparam logic [1:0] ADDR_P     = 2'd0;
    localparam logic [1:0] ADDR_E     = 2'd1;
    localparam logic [1:0] ADDR_M     = 2'd2;
    localparam logic [1:0] ADDR_CONST = 2'd3;

endpackage

// File: rtl/rsa_host_ctrl.sv
// Host-side sequencer for the RSA exponentiation core: operand registers plus one run per start.
// Optional run timeout is enabled with the RSA_HOST_TIMEOUT_EN macro.
module rsa_host_ctrl
    import rsa_host_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             core_rstb,
    output logic             core_en,
    output logic [WIDTH-1:0] core_P,
    output logic [WIDTH-1:0] core_E,
    output logic [WIDTH-1:0] core_M,
    output logic [WIDTH-1:0] core_Const,
    input  logic [WIDTH-1:0] core_C,
    input  logic             core_eoc
);

    localparam int CNT_MAX = (CLR_CYCLES > TIMEOUT_CYCLES) ? CLR_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    host_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] m_next;
    logic             write_ok;

    assign write_ok = wr_en && (state == IDLE);

    // A write landing on the same edge as start must be the modulus the check sees.
    always_comb begin
        m_next = core_M;
        if (write_ok && (wr_addr == ADDR_M)) begin
            m_next = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_P     <= '0;
            core_E     <= '0;
            core_M     <= '0;
            core_Const <= '0;
        end else if (write_ok) begin
            case (wr_addr)
                ADDR_P:     core_P     <= wr_data;
                ADDR_E:     core_E     <= wr_data;
                ADDR_M:     core_M     <= wr_data;
                ADDR_CONST: core_Const <= wr_data;
                default:    core_P     <= core_P;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            core_rstb <= 1'b0;
            core_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_rstb <= 1'b0;
                    core_en   <= 1'b0;
                    if (start) begin
                        done <= 1'b0;
                        if (!m_next[0]) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(CLR_CYCLES);
                            state <= CLEAR;
                        end
                    end
                end

                CLEAR: begin
                    if (cnt == '0) begin
                        core_rstb <= 1'b1;
                        core_en   <= 1'b1;
                        state     <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // cnt==0 marks the first RUN cycle, where a leftover eoc level is ignored.
                RUN: begin
                    if ((cnt != '0) && core_eoc) begin
                        state <= CAPTURE;
`ifdef RSA_HOST_TIMEOUT_EN
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        core_en   <= 1'b0;
                        core_rstb <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    end else begin
                        cnt <= CNT_W'(1);
                    end
`endif
                end

                CAPTURE: begin
                    result    <= core_C;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    core_en   <= 1'b0;
                    core_rstb <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Directed bench for rsa_host_ctrl with a behavioural core stub computing P^E mod M.
module tb_rsa_host_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy, done, err;
    logic [WIDTH-1:0] result;
    logic             core_rstb, core_en;
    logic [WIDTH-1:0] core_P, core_E, core_M, core_Const;
    logic [WIDTH-1:0] core_C;
    logic             core_eoc;

    int checkCount = 0;
    int errorCount = 0;
    logic stubHold = 1'b0;
    int   stubCnt;
    int   lat;

    rsa_host_ctrl #(.WIDTH(WIDTH), .CLR_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .err(err), .result(result),
        .core_rstb(core_rstb), .core_en(core_en), .core_P(core_P), .core_E(core_E),
        .core_M(core_M), .core_Const(core_Const), .core_C(core_C), .core_eoc(core_eoc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] modExp(input logic [WIDTH-1:0] p, e, m);
        int r;
        r = 1;
        if (m == 0) return '0;
        for (int i = 0; i < int'(e); i++) r = (r * int'(p)) % int'(m);
        return WIDTH'(r);
    endfunction

    // Core stand-in: raises eoc after six enabled cycles, holds it until reset.
    always @(posedge clk) begin
        if (!core_rstb) begin
            stubCnt  <= 0;
            core_eoc <= 1'b0;
            core_C   <= '0;
        end else if (core_en && !stubHold) begin
            stubCnt <= stubCnt + 1;
            if (stubCnt == 5) begin
                core_eoc <= 1'b1;
                core_C   <= modExp(core_P, core_E, core_M);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] a, input logic [WIDTH-1:0] d,
                                 input logic st);
        @(negedge clk);
        wr_en = we; wr_addr = a; wr_data = d; start = st;
        @(posedge clk);
        #1;
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic writeOperands(input logic [WIDTH-1:0] p, e, m, c);
        applyStimulus(1'b1, 2'd0, p, 1'b0);
        applyStimulus(1'b1, 2'd1, e, 1'b0);
        applyStimulus(1'b1, 2'd2, m, 1'b0);
        applyStimulus(1'b1, 2'd3, c, 1'b0);
    endtask

    task automatic waitCoreEn(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (core_en) begin n = i; break; end
        end
        if (n < 0) checkOutput("core_en_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (!busy) begin n = i; break; end
        end
        if (n < 0) checkOutput("busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_core_rstb", core_rstb, 0);
        checkOutput("rst_core_en", core_en, 0);
        checkOutput("rst_core_M", core_M, 0);
        @(negedge clk); rst = 1'b0;

        // Test 1: basic run, 5^3 mod 13 = 8
        writeOperands(8'd5, 8'd3, 8'd13, 8'd9);
        checkOutput("t1_core_P", core_P, 5);
        checkOutput("t1_core_E", core_E, 3);
        checkOutput("t1_core_M", core_M, 13);
        checkOutput("t1_core_Const", core_Const, 9);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("t1_busy_after_start", busy, 1);
        checkOutput("t1_rstb_clear", core_rstb, 0);
        checkOutput("t1_en_clear", core_en, 0);
        waitCoreEn(lat);
        checkOutput("t1_run_latency", lat, 3);
        checkOutput("t1_rstb_run", core_rstb, 1);
        waitIdle(lat);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_result", result, 8);
        checkOutput("t1_core_en_off", core_en, 0);
        checkOutput("t1_rstb_off", core_rstb, 0);

        // Test 2: even modulus rejected
        applyStimulus(1'b1, 2'd2, 8'd12, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        checkOutput("t2_err", err, 1);
        checkOutput("t2_done_cleared", done, 0);
        checkOutput("t2_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("t2_busy_stays_low", busy, 0);
            checkOutput("t2_core_en_low", core_en, 0);
        end
        checkOutput("t2_result_held", result, 8);

        // Test 4: same-cycle write of M=13 with start, old M=12
        applyStimulus(1'b1, 2'd2, 8'd13, 1'b1);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_err_cleared", err, 0);
        checkOutput("t4_core_M", core_M, 13);
        waitIdle(lat);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_result", result, 8);

        // Test 3: write and start while running are ignored
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        waitCoreEn(lat);
        applyStimulus(1'b1, 2'd0, 8'hFF, 1'b1);
        checkOutput("t3_core_P_kept", core_P, 5);
        checkOutput("t3_busy", busy, 1);
        checkOutput("t3_err", err, 0);
        waitIdle(lat);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_result", result, 8);
        @(posedge clk); #1;
        checkOutput("t3_no_restart", busy, 0);

        // Test 5: async reset during RUN
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        waitCoreEn(lat);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t5_core_en", core_en, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_result", result, 0);
        checkOutput("t5_core_P", core_P, 0);
        checkOutput("t5_core_rstb", core_rstb, 0);
        @(negedge clk); rst = 1'b0;
        writeOperands(8'd5, 8'd3, 8'd13, 8'd9);
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        waitIdle(lat);
        checkOutput("t5_rerun_result", result, 8);
        checkOutput("t5_rerun_done", done, 1);

`ifdef RSA_HOST_TIMEOUT_EN
        // Test 6: core never finishes
        stubHold = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1);
        waitCoreEn(lat);
        waitIdle(lat);
        checkOutput("t6_timeout_latency", lat, 16);
        checkOutput("t6_err", err, 1);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_result_held", result, 8);
        checkOutput("t6_core_en", core_en, 0);
        checkOutput("t6_core_rstb", core_rstb, 0);
        stubHold = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rsa_host_ctrl.md
Name: rsa_host_ctrl

Overview:
Initiator side of the RSA core's en/eoc interface. It holds the operand registers (P, E, M, Const) written by a host bus, and it sequences one modular exponentiation per start command. Sequencing covers clearing the core, asserting core_en, waiting for core_eoc and capturing core_C. The block sits between the chip-level register/SPI front end and the RSA exponentiation core.

Parameters:
WIDTH, 8, operand/result width in bits (matches the core's WIDTH)
CLR_CYCLES, 2, cycles core_rstb is held low after each accepted start (minimum 1)
TIMEOUT_CYCLES, 1024, maximum RUN-state cycles before abort (used only with the optional feature)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  host operand write strobe
wr_addr  in  2  operand select: 0=P, 1=E, 2=M, 3=Const
wr_data  in  WIDTH  operand write data
start  in  1  single-cycle start request
busy  out  1  operation in progress
done  out  1  sticky: last operation completed, result valid
err  out  1  sticky: last start rejected or aborted
result  out  WIDTH  captured ciphertext
core_rstb  out  1  active-low reset to core
core_en  out  1  core enable
core_P, core_E, core_M, core_Const  out  WIDTH each  operand registers driven to core
core_C  in  WIDTH  core result
core_eoc  in  1  core end-of-computation

Behaviour:
- Reset (async, rst=1) values:
  - State IDLE.
  - All operand registers 0, result 0.
  - busy, done, err, core_en 0; core_rstb 0.
  - Reset mid-operation aborts immediately; core_en drops in the same instant.
- Core handling:
  - core_rstb is 0 in IDLE and CLEAR, and 1 in RUN/CAPTURE.
  - The core is therefore held in reset whenever idle, so every run starts clean.
- Writes:
  - Accepted only when busy=0; the register selected by wr_addr is updated on the edge.
  - wr_en while busy=1 is ignored and does not set err.
- Start:
  - Accepted only in IDLE; start while busy is ignored.
  - If wr_en and start occur in the same IDLE cycle, the write commits and the run uses the new value.
  - Start clears done and err.
- Modulus check at start:
  - If M (after any same-cycle write) is even, including 0, then err<=1, the state stays IDLE and the core is never enabled. Montgomery reduction requires an odd modulus.
- FSM:
  - IDLE: start accepted -> CLEAR; busy<=1.
  - CLEAR: count CLR_CYCLES cycles with core_rstb=0, core_en=0 -> RUN.
  - RUN: core_rstb=1, core_en=1.
    - core_eoc=1 -> CAPTURE; core_en stays 1 for this edge.
    - core_eoc sampled in the first RUN cycle is ignored, guarding against a stale level.
  - CAPTURE: result<=core_C, done<=1, busy<=0, core_en<=0 -> IDLE.
    - Capture occurs one cycle after eoc, so the core's result register has settled.
- Latency: start at edge N -> busy=1 after N, RUN entered at N+1+CLR_CYCLES; done=1 two edges after the eoc edge.
- Persistence:
  - result holds until the next successful CAPTURE.
  - done/err are sticky until the next accepted start.
- Operand registers are never modified by the FSM.

Optional Feature:
RSA_HOST_TIMEOUT_EN:
- Defined: a counter runs in RUN. If TIMEOUT_CYCLES elapse without core_eoc, the block goes to IDLE with err<=1, done stays 0, result unchanged, and core_en/core_rstb drop to 0.
- Undefined: no counter; RUN waits indefinitely for core_eoc.

Decomposition:
- Package rsa_host_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, CAPTURE);
  - address constants ADDR_P=2'd0, ADDR_E=2'd1, ADDR_M=2'd2, ADDR_CONST=2'd3.
- Single module; no sub-module. The clear counter and the timeout counter share one counter register, reloaded on state entry.

Test Plan:
1. With the real RSA core, WIDTH=8: write P=5, E=3, M=13, Const=9; pulse start -> busy for the run, then done=1, err=0, result=8.
2. Write M=12 (even), start -> err=1 next edge, busy never rises, core_en stays 0.
3. Mid-RUN: pulse wr_en addr 0 data 0xFF and pulse start -> core_P still 5; no restart; final result=8.
4. Same-cycle wr_en (addr 2, data 13) and start from IDLE with old M=12 -> run proceeds with M=13; no err.
5. Assert rst during RUN -> all outputs reach reset values immediately; a subsequent run from test 1 gives result=8.
6. With RSA_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_eoc stub tied 0 -> err=1 and IDLE 16 cycles after RUN entry; done=0.
